cmplx_mul_host_if: RTL and testbench
====================================

# cmplx_mul_host_if

Host-side initiator for the complex multiplier's two-handshake protocol. Buffers operand pairs written by the host in an operand FIFO and drives them to the multiplier over `op_val`/`op_ready`. Collects products over `res_val`/`res_ready` into a result FIFO that the host drains. Keeps at most one operation outstanding, and only issues when result-FIFO space is already reserved, so it never stalls the multiplier in its wait-for-ready state longer than one cycle.

## Interface
- `DATA_WIDTH`, 8: width of each signed real/imag operand component.
- `FIFO_DEPTH`, 4: entries in each FIFO; power of two, ≥ 2.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `sw_rst`  in  1  synchronous software reset, active-high; same effect as `rst`, applied at the edge.
- `in_wr`  in  1  host write strobe for one operand pair.
- `in_data`  in  4*DATA_WIDTH  {op1_re, op1_im, op2_re, op2_im}, signed, MSB first.
- `in_full`  out  1  operand FIFO full.
- `op_val`  out  1  operands valid toward multiplier.
- `op_ready`  in  1  multiplier accepts operands.
- `op_data`  out  4*DATA_WIDTH  operand pair toward multiplier.
- `res_val`  in  1  multiplier result valid.
- `res_ready`  out  1  this block accepts the result.
- `res_data`  in  2*(2*DATA_WIDTH+1)  {res_re, res_im}, signed.
- `out_rd`  in  1  host pop strobe for the result FIFO.
- `out_data`  out  2*(2*DATA_WIDTH+1)  result FIFO head (first-word fall-through).
- `out_empty`  out  1  result FIFO empty.

## Operation
- Operand FIFO: a push occurs on `in_wr & ~in_full`. A write while full is dropped with no side effect; `in_full` is evaluated before the edge even if a pop happens in the same cycle.
- Result FIFO: a push occurs on the `res_val & res_ready` handshake. A pop occurs on `out_rd & ~out_empty`; a pop while empty is ignored. Simultaneous push and pop are allowed, and the count is unchanged.
- `out_data` reads 0 whenever `out_empty` is 1.
- Issue FSM, state register cleared by `rst`/`sw_rst`:
  - IDLE: `op_val`=0, `res_ready`=0. If operand FIFO is non-empty and result count < FIFO_DEPTH, load `op_data` from the operand head and go to SEND.
  - SEND: `op_val`=1, `op_data` held stable. On `op_ready`=1, pop the operand FIFO and go to WAIT_RES. Otherwise stay; `op_val` is never withdrawn.
  - WAIT_RES: `res_ready`=1. On `res_val`=1, push `res_data` into the result FIFO and go to IDLE.
- `op_val` and `res_ready` are decoded from registered state only and never depend combinationally on `op_ready`/`res_val`.
- Results leave in the same order as operands were written. No arithmetic is done here; `res_data` is stored bit-exact.
- Reset, async or sw, at any point:
  - Both FIFOs are flushed, FSM returns to IDLE, and all outputs return to reset values.
  - `sw_rst` must be shared with the multiplier so that no orphaned result returns.
- Reset values: `op_val`=0, `res_ready`=0, `op_data`=0, `in_full`=0, `out_empty`=1, `out_data`=0.

## Timing
- `in_wr` at edge k into an empty FIFO while IDLE with space: `op_val`=1 after edge k+1.
- The transfer edge is the first edge with `op_val & op_ready`. `res_ready`=1 from that edge until the `res_val` edge.
- `res_val` at edge m: `out_empty`=0 and `out_data` is valid after edge m. The FSM is in IDLE after edge m.
- Back-to-back throughput: the next `op_val` rises at edge m+1, so there are 2 block cycles per op plus multiplier latency.
- `in_full`/`out_empty` update on the same edge as the push/pop that changes them.
- Result FIFO full: the FSM stays in IDLE and `op_val` stays 0 until a host pop frees an entry. Issue resumes on the edge after the pop.

## Test plan
- Single op with DATA_WIDTH=8: write {3,4,1,2} → `op_data`=0x03040102 with `op_val` one cycle later; model returns (-5, 10) → `out_data`={17'h1FFFB, 17'h0000A}, `out_empty`=0.
- Write 4 pairs back-to-back with no `out_rd` → all 4 issue, 4 results buffered. A 5th write is issued only after one `out_rd`, and results are popped in write order.
- Multiplier holds `op_ready`=0 for 5 cycles → `op_val` and `op_data` stay stable throughout. Exactly one transfer and exactly one FIFO pop occur.
- Overflow: 5 writes while the FSM is stalled by a full result FIFO → `in_full`=1 after the 4th write, the 5th is dropped, and only 4 results ever appear.
- `out_rd` on empty and a simultaneous push/pop on a 1-entry result FIFO → the empty pop is ignored, the count stays at 1, and the head advances to the new result.
- `rst` asserted while in WAIT_RES with both FIFOs non-empty → all outputs take reset values immediately. Repeat with `sw_rst` → reset values after the next edge, then a fresh op completes normally.

Source files
------------

// File: rtl/cmplx_mul_host_if_if.sv
// Bus bundle between the host-side initiator, the host and the complex multiplier.
// The master modport is the initiator's view. The slave modport is the environment's view (host plus multiplier).
interface cmplx_mul_host_if_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned OP_W  = 4 * DATA_WIDTH;
  localparam int unsigned RES_W = 2 * (2 * DATA_WIDTH + 1);

  logic             in_wr;
  logic [OP_W-1:0]  in_data;
  logic             in_full;
  logic             op_val;
  logic             op_ready;
  logic [OP_W-1:0]  op_data;
  logic             res_val;
  logic             res_ready;
  logic [RES_W-1:0] res_data;
  logic             out_rd;
  logic [RES_W-1:0] out_data;
  logic             out_empty;

  modport master (
    input  in_wr, in_data, op_ready, res_val, res_data, out_rd,
    output in_full, op_val, op_data, res_ready, out_data, out_empty
  );

  modport slave (
    output in_wr, in_data, op_ready, res_val, res_data, out_rd,
    input  in_full, op_val, op_data, res_ready, out_data, out_empty
  );
endinterface

// File: rtl/cmplx_mul_host_if.sv
// Host-side initiator for the complex multiplier: operand FIFO -> op handshake,
// res handshake -> result FIFO, one operation outstanding with result space reserved.
module cmplx_mul_host_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  sw_rst,
  cmplx_mul_host_if_if.master  bus
);
  localparam int unsigned OP_W  = 4 * DATA_WIDTH;
  localparam int unsigned RES_W = 2 * (2 * DATA_WIDTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RES = 2'd2
  } state_e;

  state_e           state_q;
  logic             op_val_q;
  logic             res_ready_q;
  logic [OP_W-1:0]  op_data_q;

  logic [OP_W-1:0]  op_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] op_wr_ptr_q, op_wr_ptr_d;
  logic [PTR_W-1:0] op_rd_ptr_q, op_rd_ptr_d;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
  logic             in_full_q;

  logic [RES_W-1:0] res_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] res_wr_ptr_q, res_wr_ptr_d;
  logic [PTR_W-1:0] res_rd_ptr_q, res_rd_ptr_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic             out_empty_q;
  logic [RES_W-1:0] out_data_q, out_data_d;

  logic op_push, op_pop, res_push, res_pop, issue;

  // Handshake qualification, FIFO pointer/count next-state and registered head lookahead
  always_comb begin
    op_push  = bus.in_wr & ~in_full_q;
    op_pop   = (state_q == SEND) & bus.op_ready;
    res_push = res_ready_q & bus.res_val;
    res_pop  = bus.out_rd & ~out_empty_q;
    issue    = (state_q == IDLE) && (op_cnt_q != '0) &&
               (res_cnt_q != CNT_W'(FIFO_DEPTH));

    op_wr_ptr_d  = op_wr_ptr_q + PTR_W'(op_push);
    op_rd_ptr_d  = op_rd_ptr_q + PTR_W'(op_pop);
    res_wr_ptr_d = res_wr_ptr_q + PTR_W'(res_push);
    res_rd_ptr_d = res_rd_ptr_q + PTR_W'(res_pop);

    op_cnt_d = op_cnt_q;
    if (op_push && !op_pop) begin
      op_cnt_d = op_cnt_q + CNT_W'(1);
    end else if (!op_push && op_pop) begin
      op_cnt_d = op_cnt_q - CNT_W'(1);
    end

    res_cnt_d = res_cnt_q;
    if (res_push && !res_pop) begin
      res_cnt_d = res_cnt_q + CNT_W'(1);
    end else if (!res_push && res_pop) begin
      res_cnt_d = res_cnt_q - CNT_W'(1);
    end

    // The new head is the word being pushed this edge when it lands on the next read slot
    out_data_d = '0;
    if (res_cnt_d != '0) begin
      if (res_push && (res_wr_ptr_q == res_rd_ptr_d)) begin
        out_data_d = bus.res_data;
      end else begin
        out_data_d = res_mem_q[res_rd_ptr_d];
      end
    end
  end

  // FIFO storage carries no reset; validity is tracked by the counts
  always_ff @(posedge clk) begin
    if (op_push) begin
      op_mem_q[op_wr_ptr_q] <= bus.in_data;
    end
    if (res_push) begin
      res_mem_q[res_wr_ptr_q] <= bus.res_data;
    end
  end

  // FIFO pointers, counts and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_wr_ptr_q  <= '0;
      op_rd_ptr_q  <= '0;
      op_cnt_q     <= '0;
      in_full_q    <= 1'b0;
      res_wr_ptr_q <= '0;
      res_rd_ptr_q <= '0;
      res_cnt_q    <= '0;
      out_empty_q  <= 1'b1;
      out_data_q   <= '0;
    end else if (sw_rst) begin
      op_wr_ptr_q  <= '0;
      op_rd_ptr_q  <= '0;
      op_cnt_q     <= '0;
      in_full_q    <= 1'b0;
      res_wr_ptr_q <= '0;
      res_rd_ptr_q <= '0;
      res_cnt_q    <= '0;
      out_empty_q  <= 1'b1;
      out_data_q   <= '0;
    end else begin
      op_wr_ptr_q  <= op_wr_ptr_d;
      op_rd_ptr_q  <= op_rd_ptr_d;
      op_cnt_q     <= op_cnt_d;
      in_full_q    <= (op_cnt_d == CNT_W'(FIFO_DEPTH));
      res_wr_ptr_q <= res_wr_ptr_d;
      res_rd_ptr_q <= res_rd_ptr_d;
      res_cnt_q    <= res_cnt_d;
      out_empty_q  <= (res_cnt_d == '0);
      out_data_q   <= out_data_d;
    end
  end

  // Issue FSM; op_val/res_ready are registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_val_q    <= 1'b0;
      res_ready_q <= 1'b0;
      op_data_q   <= '0;
    end else if (sw_rst) begin
      state_q     <= IDLE;
      op_val_q    <= 1'b0;
      res_ready_q <= 1'b0;
      op_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue) begin
            op_data_q <= op_mem_q[op_rd_ptr_q];
            op_val_q  <= 1'b1;
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (bus.op_ready) begin
            op_val_q    <= 1'b0;
            res_ready_q <= 1'b1;
            state_q     <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (bus.res_val) begin
            res_ready_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          op_val_q    <= 1'b0;
          res_ready_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_full   = in_full_q;
  assign bus.op_val    = op_val_q;
  assign bus.op_data   = op_data_q;
  assign bus.res_ready = res_ready_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_empty = out_empty_q;

endmodule

// File: tb/tb_cmplx_mul_host_if.sv
// Bench for cmplx_mul_host_if: a behavioural multiplier with programmable ready hold-off and latency,
// plus a queue-based model of host writes and expected products.
module tb_cmplx_mul_host_if;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned OPW   = 4 * DW;
  localparam int unsigned CW    = 2 * DW + 1;
  localparam int unsigned RESW  = 2 * CW;

  logic clk = 1'b0;
  logic rst;
  logic sw_rst;

  cmplx_mul_host_if_if #(.DATA_WIDTH(DW)) hbus ();

  cmplx_mul_host_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_rst (sw_rst),
    .bus    (hbus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [RESW-1:0] exp_q [$];
  int wr_acc = 0;
  int xfer_cnt = 0;
  int ready_hold = 0;
  int latency = 2;
  bit mul_flush = 1'b1;
  int mst = 0;
  int mhold = 0;
  int mlat = 0;
  logic [OPW-1:0] mop = '0;

  // Reference complex product from the written operand pair
  function automatic logic [RESW-1:0] cmul(input logic [OPW-1:0] d);
    int ar, ai, br, bi, re, im;
    ar = $signed(d[4*DW-1 -: DW]);
    ai = $signed(d[3*DW-1 -: DW]);
    br = $signed(d[2*DW-1 -: DW]);
    bi = $signed(d[DW-1 -: DW]);
    re = ar * br - ai * bi;
    im = ar * bi + ai * br;
    return {CW'(re), CW'(im)};
  endfunction

  // Multiplier model: ready hold-off, then latency, then a one-cycle result
  always @(negedge clk) begin
    if (mul_flush) begin
      mst = 0;
      hbus.op_ready = 1'b0;
      hbus.res_val  = 1'b0;
      hbus.res_data = '0;
    end else begin
      case (mst)
        0: if (hbus.op_val) begin
             mop = hbus.op_data;
             if (ready_hold == 0) begin
               hbus.op_ready = 1'b1;
               mst = 2;
             end else begin
               mhold = ready_hold;
               mst = 1;
             end
           end
        1: begin
             mhold--;
             if (mhold == 0) begin
               hbus.op_ready = 1'b1;
               mst = 2;
             end
           end
        2: begin
             hbus.op_ready = 1'b0;
             xfer_cnt++;
             mlat = latency;
             if (mlat == 0) begin
               hbus.res_val = 1'b1;
               hbus.res_data = cmul(mop);
               mst = 3;
             end else begin
               mst = 4;
             end
           end
        4: begin
             mlat--;
             if (mlat == 0) begin
               hbus.res_val = 1'b1;
               hbus.res_data = cmul(mop);
               mst = 3;
             end
           end
        3: begin
             hbus.res_val = 1'b0;
             mst = 0;
           end
        default: mst = 0;
      endcase
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic host_write(input logic [OPW-1:0] d, output bit acc);
    acc = (wr_acc - xfer_cnt) < int'(DEPTH);
    hbus.in_wr = 1'b1;
    hbus.in_data = d;
    if (acc) begin
      wr_acc++;
      exp_q.push_back(cmul(d));
    end
    step();
    hbus.in_wr = 1'b0;
  endtask

  task automatic host_pop();
    hbus.out_rd = 1'b1;
    step();
    hbus.out_rd = 1'b0;
  endtask

  // sel: 0 result available, 1 op_val, 2 res_ready, 3 res_val
  task automatic wait_for(input int sel, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if ((sel == 0 && hbus.out_empty === 1'b0) || (sel == 1 && hbus.op_val === 1'b1) ||
          (sel == 2 && hbus.res_ready === 1'b1) || (sel == 3 && hbus.res_val === 1'b1)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; sw_rst = 1'b0;
    hbus.in_wr = 1'b0; hbus.in_data = '0; hbus.out_rd = 1'b0;
    #2 rst = 1'b1;
    step(); step();
    checks++; if (hbus.op_val !== 1'b0) begin errors++; $display("FAIL reset_op_val: got %b expected 0", hbus.op_val); end
    checks++; if (hbus.res_ready !== 1'b0) begin errors++; $display("FAIL reset_res_ready: got %b expected 0", hbus.res_ready); end
    checks++; if (hbus.op_data !== '0) begin errors++; $display("FAIL reset_op_data: got %h expected 0", hbus.op_data); end
    checks++; if (hbus.in_full !== 1'b0) begin errors++; $display("FAIL reset_in_full: got %b expected 0", hbus.in_full); end
    checks++; if (hbus.out_empty !== 1'b1) begin errors++; $display("FAIL reset_out_empty: got %b expected 1", hbus.out_empty); end
    checks++; if (hbus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", hbus.out_data); end
    rst = 1'b0;
    step();
    mul_flush = 1'b0;
    wr_acc = xfer_cnt;
    exp_q.delete();
  endtask

  task automatic test_single();
    logic [OPW-1:0] d;
    logic [RESW-1:0] e;
    bit acc, ok;
    latency = 2; ready_hold = 0;
    d = {8'd3, 8'd4, 8'd1, 8'd2};
    e = {17'h1FFFB, 17'h0000A};
    host_write(d, acc);
    checks++; if (hbus.op_val !== 1'b0) begin errors++; $display("FAIL single_op_val_early: got %b expected 0", hbus.op_val); end
    step();
    checks++; if (hbus.op_val !== 1'b1) begin errors++; $display("FAIL single_op_val: got %b expected 1", hbus.op_val); end
    checks++; if (hbus.op_data !== 32'h03040102) begin errors++; $display("FAIL single_op_data: got %h expected 03040102", hbus.op_data); end
    wait_for(0, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got no result expected one"); end
    checks++; if (hbus.out_data !== e) begin errors++; $display("FAIL single_out_data: got %h expected %h", hbus.out_data, e); end
    checks++; if (hbus.out_data !== exp_q[0]) begin errors++; $display("FAIL single_model: got %h expected %h", hbus.out_data, exp_q[0]); end
    void'(exp_q.pop_front());
    host_pop();
    checks++; if (hbus.out_empty !== 1'b1) begin errors++; $display("FAIL single_empty_after_pop: got %b expected 1", hbus.out_empty); end
    checks++; if (hbus.out_data !== '0) begin errors++; $display("FAIL single_data_when_empty: got %h expected 0", hbus.out_data); end
  endtask

  task automatic test_back_to_back();
    bit acc, ok;
    int x0;
    latency = 1; ready_hold = 0; x0 = xfer_cnt;
    for (int i = 0; i < 4; i++) begin
      host_write(OPW'($urandom), acc);
      checks++;
      if (hbus.in_full !== ((wr_acc - xfer_cnt) == int'(DEPTH))) begin
        errors++; $display("FAIL b2b_in_full: got %b expected %b", hbus.in_full, (wr_acc - xfer_cnt) == int'(DEPTH));
      end
    end
    repeat (30) step();
    checks++; if (xfer_cnt - x0 != 4) begin errors++; $display("FAIL b2b_issued: got %0d expected 4", xfer_cnt - x0); end
    host_write(OPW'($urandom), acc);
    repeat (15) step();
    checks++; if (xfer_cnt - x0 != 4) begin errors++; $display("FAIL b2b_stalled_when_full: got %0d expected 4", xfer_cnt - x0); end
    checks++; if (hbus.op_val !== 1'b0) begin errors++; $display("FAIL b2b_op_val_when_full: got %b expected 0", hbus.op_val); end
    checks++; if (hbus.out_data !== exp_q[0]) begin errors++; $display("FAIL b2b_head: got %h expected %h", hbus.out_data, exp_q[0]); end
    void'(exp_q.pop_front());
    host_pop();
    checks++; if (hbus.op_val !== 1'b0) begin errors++; $display("FAIL b2b_resume_early: got %b expected 0", hbus.op_val); end
    step();
    checks++; if (hbus.op_val !== 1'b1) begin errors++; $display("FAIL b2b_resume: got %b expected 1", hbus.op_val); end
    for (int i = 0; i < 4; i++) begin
      wait_for(0, 30, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_drain_timeout: got no result expected one"); end
      checks++; if (hbus.out_data !== exp_q[0]) begin errors++; $display("FAIL b2b_order: got %h expected %h", hbus.out_data, exp_q[0]); end
      void'(exp_q.pop_front());
      host_pop();
    end
    checks++; if (hbus.out_empty !== 1'b1) begin errors++; $display("FAIL b2b_final_empty: got %b expected 1", hbus.out_empty); end
  endtask

  task automatic test_stall();
    logic [OPW-1:0] d, cap;
    bit acc, ok;
    int x0;
    latency = 1; ready_hold = 5; x0 = xfer_cnt;
    d = OPW'($urandom);
    host_write(d, acc);
    wait_for(1, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_op_val_timeout: got 0 expected 1"); end
    cap = hbus.op_data;
    checks++; if (cap !== d) begin errors++; $display("FAIL stall_op_data: got %h expected %h", cap, d); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (hbus.op_val !== 1'b1 || hbus.op_data !== cap) begin
        errors++; $display("FAIL stall_stable: got val=%b data=%h expected val=1 data=%h", hbus.op_val, hbus.op_data, cap);
      end
    end
    wait_for(0, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_result_timeout: got no result expected one"); end
    checks++; if (hbus.out_data !== exp_q[0]) begin errors++; $display("FAIL stall_result: got %h expected %h", hbus.out_data, exp_q[0]); end
    void'(exp_q.pop_front());
    host_pop();
    repeat (10) step();
    checks++; if (xfer_cnt - x0 != 1) begin errors++; $display("FAIL stall_one_transfer: got %0d expected 1", xfer_cnt - x0); end
    checks++; if (hbus.op_val !== 1'b0) begin errors++; $display("FAIL stall_no_reissue: got %b expected 0", hbus.op_val); end
    checks++; if (hbus.out_empty !== 1'b1) begin errors++; $display("FAIL stall_empty: got %b expected 1", hbus.out_empty); end
    ready_hold = 0;
  endtask

  task automatic test_overflow();
    bit acc, ok;
    int x0;
    latency = 1; ready_hold = 0; x0 = xfer_cnt;
    for (int i = 0; i < 4; i++) host_write(OPW'($urandom), acc);
    repeat (30) step();
    for (int i = 0; i < 5; i++) begin
      host_write(OPW'($urandom), acc);
      checks++;
      if (hbus.in_full !== ((wr_acc - xfer_cnt) == int'(DEPTH))) begin
        errors++; $display("FAIL ovf_in_full_%0d: got %b expected %b", i, hbus.in_full, (wr_acc - xfer_cnt) == int'(DEPTH));
      end
    end
    checks++; if (hbus.in_full !== 1'b1) begin errors++; $display("FAIL ovf_full_after_writes: got %b expected 1", hbus.in_full); end
    checks++; if (exp_q.size() != 8) begin errors++; $display("FAIL ovf_accepted: got %0d expected 8", exp_q.size()); end
    while (exp_q.size() > 0) begin
      wait_for(0, 30, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ovf_drain_timeout: got no result expected one"); exp_q.delete(); break; end
      checks++; if (hbus.out_data !== exp_q[0]) begin errors++; $display("FAIL ovf_order: got %h expected %h", hbus.out_data, exp_q[0]); end
      void'(exp_q.pop_front());
      host_pop();
    end
    repeat (20) step();
    checks++; if (hbus.out_empty !== 1'b1) begin errors++; $display("FAIL ovf_no_extra_result: got %b expected 1", hbus.out_empty); end
    checks++; if (xfer_cnt - x0 != 8) begin errors++; $display("FAIL ovf_transfers: got %0d expected 8", xfer_cnt - x0); end
  endtask

  task automatic test_empty_and_simul_pop();
    bit acc, ok;
    latency = 3; ready_hold = 0;
    host_pop();
    checks++; if (hbus.out_empty !== 1'b1 || hbus.out_data !== '0) begin
      errors++; $display("FAIL empty_pop: got empty=%b data=%h expected empty=1 data=0", hbus.out_empty, hbus.out_data);
    end
    host_write(OPW'($urandom), acc);
    wait_for(0, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL simul_first_timeout: got no result expected one"); end
    host_write(OPW'($urandom), acc);
    wait_for(3, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL simul_res_val_timeout: got 0 expected 1"); end
    hbus.out_rd = 1'b1;
    step();
    hbus.out_rd = 1'b0;
    void'(exp_q.pop_front());
    checks++; if (hbus.out_empty !== 1'b0) begin errors++; $display("FAIL simul_count_kept: got empty=%b expected 0", hbus.out_empty); end
    checks++; if (hbus.out_data !== exp_q[0]) begin errors++; $display("FAIL simul_head_advanced: got %h expected %h", hbus.out_data, exp_q[0]); end
    void'(exp_q.pop_front());
    host_pop();
    checks++; if (hbus.out_empty !== 1'b1) begin errors++; $display("FAIL simul_single_entry: got %b expected 1", hbus.out_empty); end
  endtask

  task automatic test_reset_mid(input bit use_sw);
    bit acc, ok;
    latency = 30; ready_hold = 0;
    for (int i = 0; i < 3; i++) host_write(OPW'($urandom), acc);
    wait_for(0, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_first_timeout: got no result expected one"); end
    wait_for(2, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_wait_res_timeout: got 0 expected 1"); end
    mul_flush = 1'b1;
    if (use_sw) begin
      sw_rst = 1'b1;
      step();
    end else begin
      rst = 1'b1;
      #1;
    end
    checks++; if (hbus.op_val !== 1'b0) begin errors++; $display("FAIL rmid_op_val sw=%0d: got %b expected 0", use_sw, hbus.op_val); end
    checks++; if (hbus.res_ready !== 1'b0) begin errors++; $display("FAIL rmid_res_ready sw=%0d: got %b expected 0", use_sw, hbus.res_ready); end
    checks++; if (hbus.op_data !== '0) begin errors++; $display("FAIL rmid_op_data sw=%0d: got %h expected 0", use_sw, hbus.op_data); end
    checks++; if (hbus.in_full !== 1'b0) begin errors++; $display("FAIL rmid_in_full sw=%0d: got %b expected 0", use_sw, hbus.in_full); end
    checks++; if (hbus.out_empty !== 1'b1) begin errors++; $display("FAIL rmid_out_empty sw=%0d: got %b expected 1", use_sw, hbus.out_empty); end
    checks++; if (hbus.out_data !== '0) begin errors++; $display("FAIL rmid_out_data sw=%0d: got %h expected 0", use_sw, hbus.out_data); end
    if (use_sw) begin
      sw_rst = 1'b0;
    end else begin
      step();
      rst = 1'b0;
    end
    step();
    mul_flush = 1'b0;
    exp_q.delete();
    wr_acc = xfer_cnt;
    latency = 2;
    host_write(OPW'($urandom), acc);
    wait_for(0, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_fresh_timeout sw=%0d: got no result expected one", use_sw); end
    checks++; if (hbus.out_data !== exp_q[0]) begin errors++; $display("FAIL rmid_fresh_data sw=%0d: got %h expected %h", use_sw, hbus.out_data, exp_q[0]); end
    void'(exp_q.pop_front());
    host_pop();
    repeat (5) step();
    checks++; if (hbus.out_empty !== 1'b1) begin errors++; $display("FAIL rmid_no_orphan sw=%0d: got %b expected 1", use_sw, hbus.out_empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_empty_and_simul_pop();
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
